bip_debug_ctrl: RTL and testbench

Execution and debug controller for the BIP processor. Sits between a host command interface, the CPU and the data memory: gates CPU execution through `o_enable` (run / single-step / halt on HLT), owns the data-memory port mux so the host can dump the full data memory while the CPU is stalled, and counts executed cycles.

---
 rtl/bip_debug_ctrl.sv | 163 ++++++++++++++++
 tb/tb_bip_debug_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_debug_ctrl.sv
// BIP execution/debug controller: run/step/halt gating, data-memory dump mux, cycle counter.
// Optional cycle counter enabled by defining BIP_DEBUG_CYCLE_COUNT_EN; otherwise o_cycles is 0.
module bip_debug_ctrl #(
  parameter int NBITS_O = 11,
  parameter int NBITS_D = 16,
  parameter int OPCODE  = 5,
  parameter int CELDAS  = 512,
  parameter int CYCLE_W = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  input  logic [1:0]         i_cmd,
  output logic               o_cmd_ready,
  input  logic [OPCODE-1:0]  i_opcode,
  output logic               o_enable,
  output logic               o_halted,
  input  logic               i_cpu_Rd,
  input  logic               i_cpu_Wr,
  input  logic [NBITS_O-1:0] i_cpu_DmAddr,
  input  logic [NBITS_D-1:0] i_cpu_InData,
  output logic               o_dm_Rd,
  output logic               o_dm_Wr,
  output logic [NBITS_O-1:0] o_dm_Addr,
  output logic [NBITS_D-1:0] o_dm_InData,
  input  logic [NBITS_D-1:0] i_dm_OutData,
  output logic               o_dump_valid,
  output logic [NBITS_O-1:0] o_dump_addr,
  output logic [NBITS_D-1:0] o_dump_data,
  output logic               o_dump_last,
  input  logic               i_dump_ready,
  output logic [CYCLE_W-1:0] o_cycles
);

  typedef enum logic [2:0] {
    IDLE, RUN, STEP, DUMP_REQ, DUMP_CAP, DUMP_OUT, HALTED
  } state_t;

  typedef enum logic [1:0] {
    CMD_RUN  = 2'b00,
    CMD_STEP = 2'b01,
    CMD_HALT = 2'b10,
    CMD_DUMP = 2'b11
  } cmd_t;

  localparam logic [NBITS_O-1:0] LAST_ADDR = NBITS_O'(CELDAS - 1);

  state_t               state, nextState;
  logic                 retHalted, nextRetHalted;
  logic [NBITS_O-1:0]   dumpCnt, nextDumpCnt;
  logic [NBITS_D-1:0]   dumpData;
  logic                 isHlt, cmdAccept, inDump;

  assign isHlt     = (i_opcode == '0);
  assign o_enable  = ((state == RUN) || (state == STEP)) && !isHlt;
  assign cmdAccept = i_cmd_valid && o_cmd_ready;
  assign inDump    = (state == DUMP_REQ) || (state == DUMP_CAP) || (state == DUMP_OUT);

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    nextState     = state;
    nextRetHalted = retHalted;
    nextDumpCnt   = dumpCnt;
    case (state)
      IDLE: begin
        if (cmdAccept) begin
          case (i_cmd)
            CMD_RUN:  nextState = RUN;
            CMD_STEP: nextState = STEP;
            CMD_DUMP: begin
              nextState     = DUMP_REQ;
              nextRetHalted = 1'b0;
              nextDumpCnt   = '0;
            end
            default: ;
          endcase
        end
      end
      // A HLT opcode wins over a HALT command arriving in the same cycle.
      RUN: begin
        if (isHlt)                                 nextState = HALTED;
        else if (cmdAccept && i_cmd == CMD_HALT)   nextState = IDLE;
      end
      STEP: nextState = isHlt ? HALTED : IDLE;
      HALTED: begin
        if (cmdAccept && i_cmd == CMD_DUMP) begin
          nextState     = DUMP_REQ;
          nextRetHalted = 1'b1;
          nextDumpCnt   = '0;
        end
      end
      DUMP_REQ: nextState = DUMP_CAP;
      DUMP_CAP: nextState = DUMP_OUT;
      DUMP_OUT: begin
        if (i_dump_ready) begin
          if (dumpCnt == LAST_ADDR) begin
            nextState   = retHalted ? HALTED : IDLE;
            nextDumpCnt = '0;
          end else begin
            nextState   = DUMP_REQ;
            nextDumpCnt = dumpCnt + 1'b1;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state        <= IDLE;
      retHalted    <= 1'b0;
      dumpCnt      <= '0;
      dumpData     <= '0;
      o_halted     <= 1'b0;
      o_cmd_ready  <= 1'b1;
      o_dump_valid <= 1'b0;
      o_dump_last  <= 1'b0;
    end else begin
      state        <= nextState;
      retHalted    <= nextRetHalted;
      dumpCnt      <= nextDumpCnt;
      o_halted     <= (nextState == HALTED);
      o_cmd_ready  <= (nextState == IDLE) || (nextState == RUN) || (nextState == HALTED);
      o_dump_valid <= (nextState == DUMP_OUT);
      o_dump_last  <= (nextState == DUMP_OUT) && (nextDumpCnt == LAST_ADDR);
      if (state == DUMP_CAP) dumpData <= i_dm_OutData;
    end
  end

  assign o_dump_addr = dumpCnt;
  assign o_dump_data = dumpData;

  // The controller owns the memory port during a dump; a stalled CPU can never write.
  always_comb begin
    if (inDump) begin
      o_dm_Rd     = (state == DUMP_REQ);
      o_dm_Wr     = 1'b0;
      o_dm_Addr   = dumpCnt;
      o_dm_InData = '0;
    end else begin
      o_dm_Rd     = i_cpu_Rd;
      o_dm_Wr     = i_cpu_Wr && o_enable;
      o_dm_Addr   = i_cpu_DmAddr;
      o_dm_InData = i_cpu_InData;
    end
  end

`ifdef BIP_DEBUG_CYCLE_COUNT_EN
  logic [CYCLE_W-1:0] cycleCnt;

  always_ff @(posedge i_clock) begin
    if (i_reset)                           cycleCnt <= '0;
    else if (o_enable && cycleCnt != '1)   cycleCnt <= cycleCnt + CYCLE_W'(1);
  end

  assign o_cycles = cycleCnt;
`else
  assign o_cycles = '0;
`endif

endmodule

// File: tb/tb_bip_debug_ctrl.sv
// Self-checking bench for bip_debug_ctrl: scoreboarded dump stream plus directed/random control checks.
module tb_bip_debug_ctrl;

  localparam int NBITS_O = 11;
  localparam int NBITS_D = 16;
  localparam int OPCODE  = 5;
  localparam int CELDAS  = 4;
  localparam int CYCLE_W = 32;

  localparam logic [1:0] C_RUN = 2'b00, C_STEP = 2'b01, C_HALT = 2'b10, C_DUMP = 2'b11;

  logic               i_clock = 1'b0;
  logic               i_reset = 1'b1;
  logic               i_cmd_valid = 1'b0;
  logic [1:0]         i_cmd = 2'b00;
  logic               o_cmd_ready;
  logic [OPCODE-1:0]  i_opcode = 5'd3;
  logic               o_enable, o_halted;
  logic               i_cpu_Rd = 1'b0, i_cpu_Wr = 1'b0;
  logic [NBITS_O-1:0] i_cpu_DmAddr = '0;
  logic [NBITS_D-1:0] i_cpu_InData = '0;
  logic               o_dm_Rd, o_dm_Wr;
  logic [NBITS_O-1:0] o_dm_Addr;
  logic [NBITS_D-1:0] o_dm_InData;
  logic [NBITS_D-1:0] i_dm_OutData;
  logic               o_dump_valid, o_dump_last;
  logic [NBITS_O-1:0] o_dump_addr;
  logic [NBITS_D-1:0] o_dump_data;
  logic               i_dump_ready = 1'b1;
  logic [CYCLE_W-1:0] o_cycles;

  bip_debug_ctrl #(
    .NBITS_O(NBITS_O), .NBITS_D(NBITS_D), .OPCODE(OPCODE), .CELDAS(CELDAS), .CYCLE_W(CYCLE_W)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd), .o_cmd_ready(o_cmd_ready),
    .i_opcode(i_opcode), .o_enable(o_enable), .o_halted(o_halted),
    .i_cpu_Rd(i_cpu_Rd), .i_cpu_Wr(i_cpu_Wr), .i_cpu_DmAddr(i_cpu_DmAddr), .i_cpu_InData(i_cpu_InData),
    .o_dm_Rd(o_dm_Rd), .o_dm_Wr(o_dm_Wr), .o_dm_Addr(o_dm_Addr), .o_dm_InData(o_dm_InData),
    .i_dm_OutData(i_dm_OutData),
    .o_dump_valid(o_dump_valid), .o_dump_addr(o_dump_addr), .o_dump_data(o_dump_data),
    .o_dump_last(o_dump_last), .i_dump_ready(i_dump_ready),
    .o_cycles(o_cycles)
  );

  always #5 i_clock = ~i_clock;

  // Data memory: synchronous read, contents owned by the bench.
  logic [NBITS_D-1:0] mem [0:(1<<NBITS_O)-1];
  logic [NBITS_D-1:0] rdData;
  always @(posedge i_clock) if (o_dm_Rd) rdData <= mem[o_dm_Addr];
  assign i_dm_OutData = rdData;

  typedef struct {
    logic [NBITS_O-1:0] addr;
    logic [NBITS_D-1:0] data;
    logic               last;
  } word_t;
  word_t expQ[$];

  int checks = 0, errors = 0;
  int enCount = 0, busyCount = 0, wordCount = 0;
  int expTotal = 0;
  bit cpuStalled = 1'b0;
  bit randReady = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expCyc(input int n);
`ifdef BIP_DEBUG_CYCLE_COUNT_EN
    return 32'(n);
`else
    return 32'(n) & 32'h0;
`endif
  endfunction

  // Monitor: enable/busy accounting, stall-write guard, dump scoreboard.
  always @(negedge i_clock) begin
    if (!i_reset) begin
      if (o_enable) enCount++;
      if (!o_cmd_ready) busyCount++;
      if (i_cpu_Wr && cpuStalled) check("dm_wr_while_stalled", {31'b0, o_dm_Wr}, 32'd0);
      if (o_dump_last && !o_dump_valid) check("last_without_valid", {31'b0, o_dump_valid}, 32'd1);
      if (o_dump_valid) begin
        if (expQ.size() == 0) begin
          check("dump_unexpected", {31'b0, o_dump_valid}, 32'd0);
        end else if (i_dump_ready) begin
          word_t e;
          e = expQ.pop_front();
          wordCount++;
          check("dump_addr", 32'(o_dump_addr), 32'(e.addr));
          check("dump_data", 32'(o_dump_data), 32'(e.data));
          check("dump_last", {31'b0, o_dump_last}, {31'b0, e.last});
          check("dump_dm_wr", {31'b0, o_dm_Wr}, 32'd0);
        end else begin
          check("stall_addr", 32'(o_dump_addr), 32'(expQ[0].addr));
          check("stall_data", 32'(o_dump_data), 32'(expQ[0].data));
        end
      end
    end
  end

  always @(posedge i_clock) begin
    if (randReady) begin
      #1 i_dump_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic sendCmd(input logic [1:0] c);
    int n = 0;
    while (!o_cmd_ready && n < 100) begin step(); n++; end
    if (n == 100) check("cmd_ready_wait", {31'b0, o_cmd_ready}, 32'd1);
    i_cmd_valid = 1'b1;
    i_cmd = c;
    step();
    i_cmd_valid = 1'b0;
  endtask

  task automatic fillMem(input bit rnd);
    for (int a = 0; a < CELDAS; a++)
      mem[a] = rnd ? NBITS_D'($urandom) : NBITS_D'(16'hA000 + a);
  endtask

  task automatic pushDump();
    for (int a = 0; a < CELDAS; a++) begin
      word_t w;
      w.addr = NBITS_O'(a);
      w.data = mem[a];
      w.last = (a == CELDAS - 1);
      expQ.push_back(w);
    end
  endtask

  task automatic waitDump(input int maxc);
    bit done = 1'b0;
    for (int i = 0; i < maxc && !done; i++) begin
      step();
      if (expQ.size() == 0 && o_cmd_ready) done = 1'b1;
    end
    if (!done) check("dump_timeout", {31'b0, o_cmd_ready}, 32'd2);
  endtask

  task automatic waitAddr(input logic [NBITS_O-1:0] a);
    int n = 0;
    while (!(o_dump_valid && o_dump_addr == a) && n < 100) begin step(); n++; end
    if (n == 100) check("wait_addr_timeout", 32'(o_dump_addr), 32'(a));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0, b0, w0, k;
    logic [NBITS_O-1:0] ra;
    logic [NBITS_D-1:0] rd;
    for (int a = 0; a < (1 << NBITS_O); a++) mem[a] = '0;

    // Reset state
    repeat (3) step();
    i_reset = 1'b0;
    #1;
    check("rst_enable", {31'b0, o_enable}, 32'd0);
    check("rst_halted", {31'b0, o_halted}, 32'd0);
    check("rst_cmd_ready", {31'b0, o_cmd_ready}, 32'd1);
    check("rst_dump_valid", {31'b0, o_dump_valid}, 32'd0);
    check("rst_dump_last", {31'b0, o_dump_last}, 32'd0);
    check("rst_dump_addr", 32'(o_dump_addr), 32'd0);
    check("rst_dump_data", 32'(o_dump_data), 32'd0);
    check("rst_cycles", o_cycles, 32'd0);

    // RUN 10 cycles then HALT; CPU writes pass while enabled
    e0 = enCount;
    sendCmd(C_RUN);
    ra = NBITS_O'($urandom); rd = NBITS_D'($urandom);
    i_cpu_Wr = 1'b1; i_cpu_DmAddr = ra; i_cpu_InData = rd;
    #1;
    check("run_enable", {31'b0, o_enable}, 32'd1);
    check("run_dm_wr", {31'b0, o_dm_Wr}, 32'd1);
    check("run_dm_addr", 32'(o_dm_Addr), 32'(ra));
    check("run_dm_data", 32'(o_dm_InData), 32'(rd));
    repeat (9) step();
    sendCmd(C_HALT);
    check("idle_dm_wr_stalled", {31'b0, o_dm_Wr}, 32'd0);
    i_cpu_Wr = 1'b0;
    expTotal += 10;
    check("run10_enables", 32'(enCount - e0), 32'd10);
    check("run10_cycles", o_cycles, expCyc(expTotal));
    check("run10_halted", {31'b0, o_halted}, 32'd0);
    check("run10_ready", {31'b0, o_cmd_ready}, 32'd1);

    // STEP from IDLE
    e0 = enCount;
    sendCmd(C_STEP);
    check("step_enable", {31'b0, o_enable}, 32'd1);
    check("step_ready", {31'b0, o_cmd_ready}, 32'd0);
    repeat (3) step();
    expTotal += 1;
    check("step_enables", 32'(enCount - e0), 32'd1);
    check("step_cycles", o_cycles, expCyc(expTotal));
    check("step_ready_after", {31'b0, o_cmd_ready}, 32'd1);

    // RUN, HLT at cycle 5 with simultaneous HALT command
    e0 = enCount;
    sendCmd(C_RUN);
    repeat (4) step();
    i_opcode = '0;
    i_cmd_valid = 1'b1; i_cmd = C_HALT;
    #1;
    check("hlt_enable_low", {31'b0, o_enable}, 32'd0);
    step();
    i_cmd_valid = 1'b0;
    check("hlt_halted", {31'b0, o_halted}, 32'd1);
    expTotal += 4;
    check("hlt_enables", 32'(enCount - e0), 32'd4);
    i_opcode = 5'd3;
    e0 = enCount;
    sendCmd(C_RUN);
    repeat (3) step();
    check("halted_run_ignored", {31'b0, o_enable}, 32'd0);
    check("halted_stays", {31'b0, o_halted}, 32'd1);
    check("halted_no_enables", 32'(enCount - e0), 32'd0);
    check("halted_cycles", o_cycles, expCyc(expTotal));

    // Dump from HALTED, fixed pattern, ready held high
    cpuStalled = 1'b1; i_cpu_Wr = 1'b1;
    fillMem(1'b0);
    pushDump();
    b0 = busyCount; w0 = wordCount;
    i_dump_ready = 1'b1;
    sendCmd(C_DUMP);
    waitDump(200);
    check("dump1_words", 32'(wordCount - w0), 32'(CELDAS));
    check("dump1_busy_cycles", 32'(busyCount - b0), 32'(3 * CELDAS));
    check("dump1_halted", {31'b0, o_halted}, 32'd1);
    check("dump1_addr_clear", 32'(o_dump_addr), 32'd0);

    // Dump with word 1 stalled 5 cycles, random contents
    fillMem(1'b1);
    pushDump();
    b0 = busyCount;
    sendCmd(C_DUMP);
    waitAddr(NBITS_O'(1));
    i_dump_ready = 1'b0;
    repeat (5) step();
    i_dump_ready = 1'b1;
    waitDump(200);
    check("dump2_busy_cycles", 32'(busyCount - b0), 32'(3 * CELDAS + 5));
    check("dump2_halted", {31'b0, o_halted}, 32'd1);

    // Reset during word 2
    fillMem(1'b1);
    pushDump();
    sendCmd(C_DUMP);
    waitAddr(NBITS_O'(2));
    i_reset = 1'b1;
    step();
    expQ.delete();
    expTotal = 0;
    check("mid_rst_enable", {31'b0, o_enable}, 32'd0);
    check("mid_rst_halted", {31'b0, o_halted}, 32'd0);
    check("mid_rst_ready", {31'b0, o_cmd_ready}, 32'd1);
    check("mid_rst_valid", {31'b0, o_dump_valid}, 32'd0);
    check("mid_rst_last", {31'b0, o_dump_last}, 32'd0);
    check("mid_rst_addr", 32'(o_dump_addr), 32'd0);
    check("mid_rst_data", 32'(o_dump_data), 32'd0);
    check("mid_rst_cycles", o_cycles, 32'd0);
    i_reset = 1'b0;
    step();

    // Dump from IDLE with random ready: restarts at 0, returns to IDLE
    cpuStalled = 1'b1; i_cpu_Wr = 1'b1;
    fillMem(1'b1);
    pushDump();
    w0 = wordCount;
    randReady = 1'b1;
    sendCmd(C_DUMP);
    waitDump(400);
    randReady = 1'b0;
    step();
    i_dump_ready = 1'b1;
    check("dump3_words", 32'(wordCount - w0), 32'(CELDAS));
    check("dump3_idle", {31'b0, o_halted}, 32'd0);
    check("dump3_ready", {31'b0, o_cmd_ready}, 32'd1);
    cpuStalled = 1'b0; i_cpu_Wr = 1'b0;

    // Random-length run
    for (int r = 0; r < 3; r++) begin
      k = $urandom_range(2, 20);
      e0 = enCount;
      sendCmd(C_RUN);
      repeat (k - 1) step();
      sendCmd(C_HALT);
      expTotal += k;
      check("rand_run_enables", 32'(enCount - e0), 32'(k));
      check("rand_run_cycles", o_cycles, expCyc(expTotal));
    end

    // STEP onto HLT opcode: no execution, goes HALTED
    i_opcode = '0;
    e0 = enCount;
    sendCmd(C_STEP);
    check("step_hlt_enable", {31'b0, o_enable}, 32'd0);
    step();
    check("step_hlt_halted", {31'b0, o_halted}, 32'd1);
    check("step_hlt_enables", 32'(enCount - e0), 32'd0);
    check("step_hlt_cycles", o_cycles, expCyc(expTotal));

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
